reg_file_dump_ctrl: RTL and testbench

Sequencer that snapshots the philosophy_v_core architectural register file for debug and self-check.
- On `start` it halts the core through a halt request/acknowledge handshake.
- It then walks register addresses 0..NUM_REGS-1 over a dedicated register-file read port and streams each (address, data) pair out on a valid/ready interface.
- When the walk ends or is aborted, it releases the core.
- It sits beside the register file, between the core pipeline control and a debug/trace consumer.

---
 rtl/philv_dbg_pkg.sv | 27 ++
 rtl/reg_file_dump_ctrl_if.sv | 45 ++++
 rtl/reg_file_dump_ctrl_chk.sv | 34 +++
 rtl/reg_file_dump_ctrl.sv | 150 +++++++++++++++
 tb/tb_reg_file_dump_ctrl.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/philv_dbg_pkg.sv
// Shared definitions for the philosophy_v_core debug register-file dump path:
// controller state encoding, default geometry and a small state decode helper.
package philv_dbg_pkg;

  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_DATA_W   = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HALT    = 3'd1,
    ST_READ    = 3'd2,
    ST_SEND    = 3'd3,
    ST_RELEASE = 3'd4
  } dump_state_e;

  // True in the states where the core must be kept stalled.
  function automatic logic core_held(input dump_state_e st);
    logic held;
    case (st)
      ST_HALT, ST_READ, ST_SEND: held = 1'b1;
      default:                   held = 1'b0;
    endcase
    return held;
  endfunction

endpackage

// File: rtl/reg_file_dump_ctrl_if.sv
// Signal bundle between the dump controller, the core halt logic, the
// register-file debug read port and the trace consumer.
interface reg_file_dump_ctrl_if
  import philv_dbg_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              start;
  logic              abort;
  logic              halt_req;
  logic              halt_ack;
  logic              rf_ren;
  logic [ADDR_W-1:0] rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              done;

  // Controller side.
  modport master (
    input  start, abort, halt_ack, rf_rdata, out_ready,
    output halt_req, rf_ren, rf_raddr, out_valid, out_addr, out_data,
           out_last, busy, done
  );

  // Environment side: core, register file and stream consumer.
  modport slave (
    output start, abort, halt_ack, rf_rdata, out_ready,
    input  halt_req, rf_ren, rf_raddr, out_valid, out_addr, out_data,
           out_last, busy, done
  );

  // Passive observer for protocol checkers.
  modport monitor (
    input abort, halt_req, halt_ack, rf_ren, out_valid, out_ready,
          out_addr, out_data, out_last, busy, done
  );

endinterface

// File: rtl/reg_file_dump_ctrl_chk.sv
// Protocol checker for the dump controller and its environment. Bind or
// instantiate next to the controller; it only observes the bundle.
module reg_file_dump_ctrl_chk (
  input logic                   clk,
  input logic                   rstb,
  reg_file_dump_ctrl_if.monitor bus
);

  // A stalled beat must not change or vanish unless it is aborted.
  a_beat_hold: assert property (@(posedge clk) disable iff (!rstb)
    (bus.out_valid && !bus.out_ready && !bus.abort) |=>
      (bus.out_valid && $stable(bus.out_addr) && $stable(bus.out_data) && $stable(bus.out_last)));

  // Beats only flow while the core is being held.
  a_valid_held: assert property (@(posedge clk) disable iff (!rstb)
    bus.out_valid |-> bus.halt_req);

  // The core must stay stalled while beats are streaming.
  a_ack_stable: assert property (@(posedge clk) disable iff (!rstb)
    bus.out_valid |-> bus.halt_ack);

  // done is a single-cycle pulse.
  a_done_pulse: assert property (@(posedge clk) disable iff (!rstb)
    bus.done |=> !bus.done);

  // Each register read lasts one cycle.
  a_ren_pulse: assert property (@(posedge clk) disable iff (!rstb)
    bus.rf_ren |=> !bus.rf_ren);

  // An idle controller drives nothing toward the core or the consumer.
  a_idle_quiet: assert property (@(posedge clk) disable iff (!rstb)
    !bus.busy |-> (!bus.halt_req && !bus.out_valid));

endmodule

// File: rtl/reg_file_dump_ctrl.sv
// Register-file dump sequencer: halts the core, walks every architectural
// register over the debug read port and streams (address, data) beats out,
// then releases the core. All outputs come straight from flops.
module reg_file_dump_ctrl
  import philv_dbg_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W
) (
  input logic                  clk,
  input logic                  rstb,
  reg_file_dump_ctrl_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

  dump_state_e       r_state;
  dump_state_e       w_next;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] w_idx_next;
  logic              w_hs;

  logic              r_halt_req;
  logic              r_rf_ren;
  logic              r_out_valid;
  logic              r_out_last;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_out_addr;
  logic [DATA_W-1:0] r_out_data;

  // A beat leaves when SEND meets a ready consumer.
  assign w_hs = (r_state == ST_SEND) && bus.out_ready;

  // Next-state and next-index decode; abort has priority over a handshake.
  always_comb begin
    w_next     = r_state;
    w_idx_next = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_next     = ST_HALT;
          w_idx_next = {ADDR_W{1'b0}};
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_HALT: begin
        if (bus.abort) begin
          w_next = ST_RELEASE;
        end else if (bus.halt_ack) begin
          w_next = ST_READ;
        end else begin
          w_next = ST_HALT;
        end
      end
      ST_READ: begin
        if (bus.abort) begin
          w_next = ST_RELEASE;
        end else begin
          w_next = ST_SEND;
        end
      end
      ST_SEND: begin
        if (bus.abort) begin
          w_next = ST_RELEASE;
        end else if (w_hs) begin
          if (r_out_last) begin
            w_next = ST_RELEASE;
          end else begin
            w_next     = ST_READ;
            w_idx_next = r_idx + IDX_ONE;
          end
        end else begin
          w_next = ST_SEND;
        end
      end
      ST_RELEASE: begin
        if (!bus.halt_ack) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_RELEASE;
        end
      end
      default: begin
        w_next     = ST_IDLE;
        w_idx_next = {ADDR_W{1'b0}};
      end
    endcase
  end

  // State and walk-index registers.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_state <= ST_IDLE;
      r_idx   <= {ADDR_W{1'b0}};
    end else begin
      r_state <= w_next;
      r_idx   <= w_idx_next;
    end
  end

  // Output flops, loaded from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_halt_req  <= 1'b0;
      r_rf_ren    <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_halt_req  <= core_held(w_next);
      r_rf_ren    <= (w_next == ST_READ);
      r_out_valid <= (w_next == ST_SEND);
      r_busy      <= (w_next != ST_IDLE);
      r_done      <= (r_state == ST_RELEASE) && (w_next == ST_IDLE);
    end
  end

  // One-entry beat holding register, loaded only in READ so the beat stays
  // frozen for as long as the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_out_addr <= {ADDR_W{1'b0}};
      r_out_data <= {DATA_W{1'b0}};
      r_out_last <= 1'b0;
    end else if (r_state == ST_READ) begin
      r_out_addr <= r_idx;
      r_out_data <= bus.rf_rdata;
      r_out_last <= (r_idx == LAST_IDX);
    end else begin
      r_out_addr <= r_out_addr;
      r_out_data <= r_out_data;
      r_out_last <= r_out_last;
    end
  end

  assign bus.halt_req  = r_halt_req;
  assign bus.rf_ren    = r_rf_ren;
  assign bus.rf_raddr  = r_idx;
  assign bus.out_valid = r_out_valid;
  assign bus.out_addr  = r_out_addr;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_reg_file_dump_ctrl.sv
// Self-checking bench for reg_file_dump_ctrl: a cycle table for the basic
// handshakes, then full dumps with backpressure, abort, reset and late ack.
module tb_reg_file_dump_ctrl;
  import philv_dbg_pkg::*;

  localparam int NR = 32;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  reg_file_dump_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  reg_file_dump_ctrl #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW)) u_dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  reg_file_dump_ctrl_chk u_chk (.clk(clk), .rstb(rstb), .bus(bus));

  // Register file model.
  logic [DW-1:0] rf_mem [NR];
  assign bus.rf_rdata = rf_mem[bus.rf_raddr];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Core model: halt_ack follows halt_req after ack_delay cycles, or manual.
  logic ack_manual_en = 1'b1;
  logic ack_manual    = 1'b0;
  logic ack_model     = 1'b0;
  int   ack_delay     = 2;
  int   ack_cnt       = 0;
  int   cyc           = 0;
  logic [3:0] rdy_seq = 4'b1001;
  logic rdy_pat       = 1'b1;
  int   rdy_mode      = 2;
  logic ready_manual  = 1'b0;

  assign bus.halt_ack  = ack_manual_en ? ack_manual : ack_model;
  assign bus.out_ready = (rdy_mode == 0) ? 1'b1 : ((rdy_mode == 1) ? rdy_pat : ready_manual);

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rdy_pat <= rdy_seq[cyc[1:0]];
    if (bus.halt_req == ack_model) ack_cnt <= 0;
    else if (ack_cnt >= ack_delay - 1) begin
      ack_model <= bus.halt_req;
      ack_cnt   <= 0;
    end else ack_cnt <= ack_cnt + 1;
  end

  // Stream scoreboard, sampled on the falling edge.
  logic mon_en = 1'b0;
  int beats = 0, exp_addr = 0, done_cnt = 0, stall_chk = 0, fall_cyc = 0, done_cyc = 0;
  logic prev_stall = 1'b0, prev_ack = 1'b0, prev_last = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (prev_ack && !bus.halt_ack) fall_cyc = cyc;
    prev_ack = bus.halt_ack;
    if (mon_en) begin
      if (bus.out_valid && prev_stall) begin
        check("stall_hold", 64'({bus.out_addr, bus.out_data, bus.out_last}),
              64'({prev_addr, prev_data, prev_last}));
        stall_chk++;
      end
      if (bus.out_valid && bus.out_ready) begin
        check("beat", 64'({bus.out_addr, bus.out_data, bus.out_last}),
              64'({AW'(exp_addr), 32'h1000_0000 + 32'(exp_addr), (exp_addr == NR - 1)}));
        beats++;
        exp_addr++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_addr  = bus.out_addr;
      prev_data  = bus.out_data;
      prev_last  = bus.out_last;
    end else prev_stall = 1'b0;
  end

  typedef struct {
    logic rs, st, ab, ak, rd;
    logic hq, rn; logic [AW-1:0] ra;
    logic vl, co; logic [AW-1:0] ad; logic [DW-1:0] dt; logic ls, bs, dn;
  } vec_t;

  function automatic vec_t mk(logic rs, logic st, logic ab, logic ak, logic rd,
                              logic hq, logic rn, logic [AW-1:0] ra, logic vl, logic co,
                              logic [AW-1:0] ad, logic [DW-1:0] dt, logic ls, logic bs, logic dn);
    vec_t v;
    v.rs = rs; v.st = st; v.ab = ab; v.ak = ak; v.rd = rd;
    v.hq = hq; v.rn = rn; v.ra = ra; v.vl = vl; v.co = co;
    v.ad = ad; v.dt = dt; v.ls = ls; v.bs = bs; v.dn = dn;
    return v;
  endfunction

  task automatic wait_done(input int base, input int budget, input string name);
    int n = 0;
    while (done_cnt == base && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == base) check(name, 64'd0, 64'd1);
  endtask

  task automatic wait_read(input logic [AW-1:0] a, input string name);
    int n = 0;
    while (!(bus.rf_ren && bus.rf_raddr == a) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!(bus.rf_ren && bus.rf_raddr == a)) check(name, 64'd0, 64'd1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic clear_sb();
    beats = 0;
    exp_addr = 0;
    stall_chk = 0;
  endtask

  vec_t tbl [22];

  initial begin
    int base;
    logic ok;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    for (int i = 0; i < NR; i++) rf_mem[i] = 32'h1000_0000 + 32'(i);

    //             rs    st    ab    ak    rd    hq    rn    ra    vl    co    ad    dt             ls    bs    dn
    tbl[0]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 32'h0,         1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 32'h0,         1'b0, 1'b0, 1'b0);
    tbl[2]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 1'b1, 1'b0);
    tbl[3]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 1'b1, 1'b0);
    tbl[4]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 1'b1, 1'b0);
    tbl[5]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 32'h1000_0000, 1'b0, 1'b1, 1'b0);
    tbl[6]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 32'h1000_0000, 1'b0, 1'b1, 1'b0);
    tbl[7]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 1'b1, 1'b0);
    tbl[8]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 5'd1, 32'h1000_0001, 1'b0, 1'b1, 1'b0);
    tbl[9]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 1'b1, 1'b0);
    tbl[10] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 1'b1, 1'b0);
    tbl[11] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 1'b0, 1'b1);
    tbl[12] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 1'b0, 1'b0);
    tbl[13] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 1'b1, 1'b0);
    tbl[14] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 1'b1, 1'b0);
    tbl[15] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 32'h1000_0000, 1'b0, 1'b1, 1'b0);
    tbl[16] = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 1'b1, 1'b0);
    tbl[17] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 1'b0, 1'b1);
    tbl[18] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 1'b0, 1'b0);
    tbl[19] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 1'b1, 1'b0);
    tbl[20] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 32'h0,         1'b0, 1'b0, 1'b0);
    tbl[21] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 32'h0,         1'b0, 1'b0, 1'b0);

    // Cycle table with manual halt_ack and out_ready.
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      rstb         = tbl[i].rs;
      bus.start    = tbl[i].st;
      bus.abort    = tbl[i].ab;
      ack_manual   = tbl[i].ak;
      ready_manual = tbl[i].rd;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_ctrl", i),
            64'({bus.halt_req, bus.rf_ren, (tbl[i].rn ? bus.rf_raddr : 5'd0), bus.out_valid, bus.busy, bus.done}),
            64'({tbl[i].hq, tbl[i].rn, tbl[i].ra, tbl[i].vl, tbl[i].bs, tbl[i].dn}));
      if (tbl[i].co)
        check($sformatf("vec%0d_beat", i), 64'({bus.out_addr, bus.out_data, bus.out_last}),
              64'({tbl[i].ad, tbl[i].dt, tbl[i].ls}));
    end

    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    ack_manual_en = 1'b0;
    repeat (4) @(negedge clk);

    // Basic dump, ready tied high.
    rdy_mode = 0; ack_delay = 2; clear_sb(); mon_en = 1'b1;
    base = done_cnt;
    pulse_start();
    wait_done(base, 300, "basic_timeout");
    check("basic_beats", 64'(beats), 64'd32);
    check("basic_done_after_ackfall", 64'(done_cyc - fall_cyc), 64'd1);
    repeat (3) @(negedge clk);
    check("basic_idle", 64'({bus.busy, bus.halt_req, bus.out_valid}), 64'd0);
    check("basic_one_done", 64'(done_cnt - base), 64'd1);

    // Backpressure, ready pattern 1,0,0,1.
    rdy_mode = 1; clear_sb();
    base = done_cnt;
    pulse_start();
    wait_done(base, 600, "bp_timeout");
    check("bp_beats", 64'(beats), 64'd32);
    check("bp_stalls_seen", 64'(stall_chk > 0), 64'd1);

    // Abort while addr 7 is stalled.
    repeat (4) @(negedge clk);
    rdy_mode = 2; ready_manual = 1'b1; clear_sb();
    base = done_cnt;
    pulse_start();
    wait_read(5'd7, "abort_read7_timeout");
    ready_manual = 1'b0;
    @(negedge clk);
    check("abort_send7", 64'({bus.out_valid, bus.out_addr}), 64'({1'b1, 5'd7}));
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_drop", 64'({bus.out_valid, bus.halt_req, bus.busy}), 64'({1'b0, 1'b0, 1'b1}));
    wait_done(base, 100, "abort_done_timeout");
    check("abort_beats", 64'(beats), 64'd7);
    check("abort_done_after_ackfall", 64'(done_cyc - fall_cyc), 64'd1);

    // Reset during READ of addr 12, then restart.
    repeat (4) @(negedge clk);
    rdy_mode = 0; clear_sb();
    pulse_start();
    wait_read(5'd12, "rst_read12_timeout");
    rstb = 1'b0;
    @(posedge clk);
    #1;
    check("rst_outputs_zero", 64'({bus.halt_req, bus.rf_ren, bus.rf_raddr, bus.out_valid, bus.out_addr,
                                   bus.out_data, bus.out_last, bus.busy, bus.done}), 64'd0);
    @(negedge clk);
    rstb = 1'b1;
    base = done_cnt;
    repeat (10) @(negedge clk);
    check("rst_no_done", 64'(done_cnt - base), 64'd0);
    check("rst_beats_before", 64'(beats), 64'd12);
    clear_sb();
    pulse_start();
    wait_done(base, 300, "rst_restart_timeout");
    check("rst_restart_beats", 64'(beats), 64'd32);

    // Late ack and start pulses during SEND.
    repeat (4) @(negedge clk);
    ack_delay = 50; clear_sb();
    base = done_cnt;
    pulse_start();
    ok = 1'b1;
    for (int k = 0; k < 45; k++) begin
      if (!(bus.halt_req && !bus.out_valid && !bus.halt_ack)) ok = 1'b0;
      @(negedge clk);
    end
    check("late_ack_hold", 64'(ok), 64'd1);
    for (int k = 0; k < 700 && done_cnt == base; k++) begin
      bus.start = bus.out_valid;
      @(negedge clk);
    end
    bus.start = 1'b0;
    if (done_cnt == base) check("late_done_timeout", 64'd0, 64'd1);
    check("late_beats", 64'(beats), 64'd32);
    repeat (20) @(negedge clk);
    check("late_single_dump", 64'({bus.busy, 32'(done_cnt - base)}), 64'({1'b0, 32'd1}));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time bound.
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
